// File: rtl/mipi_rx_aligner.sv
// MIPI HS receive aligner: per-lane sync-byte hunt, bit-offset lock and FIFO deskew into aligned bytes.
// Output registered one cycle after all lanes hold data; no back-pressure, overflow or lock timeout goes to ERROR.

module mipi_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             bypass;
   logic             wr_en;
   logic             rd_en;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   // An empty FIFO pushed and popped in the same cycle passes the byte straight through.
   assign bypass = push && pop && empty;
   assign wr_en  = push && !bypass && (!full || pop);
   assign rd_en  = pop && !empty;
   assign dout   = empty ? din : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_next(wr_ptr);
         if (rd_en) rd_ptr <= ptr_next(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end
endmodule

module mipi_rx_aligner #(
   parameter int         LANES        = 2,
   parameter int         DESKEW_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE    = 8'hB8,
   parameter int         SYNC_TIMEOUT = 8
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               hs_en,
   input  logic [LANES*8-1:0] rx_data,
   input  logic               rx_valid,
   output logic [LANES*8-1:0] byte_data,
   output logic               byte_valid,
   output logic [LANES-1:0]   lane_sync,
   output logic               sync_err,
   output logic [1:0]         state
);
   if (LANES < 1 || LANES > 4) begin : g_bad_lanes
      $fatal(1, "mipi_rx_aligner: LANES must be 1..4");
   end
   if (DESKEW_DEPTH < 2 || DESKEW_DEPTH > 8) begin : g_bad_depth
      $fatal(1, "mipi_rx_aligner: DESKEW_DEPTH must be 2..8");
   end
   if (SYNC_TIMEOUT < 1 || SYNC_TIMEOUT > 255) begin : g_bad_timeout
      $fatal(1, "mipi_rx_aligner: SYNC_TIMEOUT must be 1..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      ACTIVE = 2'd2,
      ERROR  = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               hs_en_q;
   logic [7:0]         cnt_q;
   logic [8:0]         cnt_inc;
   logic [LANES*8-1:0] prev_q;
   logic [LANES*3-1:0] offs_q;
   logic [LANES*3-1:0] hit_k;
   logic [LANES-1:0]   lock_new;
   logic [LANES-1:0]   push;
   logic [LANES-1:0]   avail;
   logic [LANES-1:0]   overflow;
   logic [LANES-1:0]   fifo_full;
   logic [LANES-1:0]   fifo_empty;
   logic [LANES*8-1:0] fifo_din;
   logic [LANES*8-1:0] fifo_dout;
   logic               in_flow;
   logic               pop;
   logic               flush;
   logic               hunt_entry;
   logic               err_set;
   logic               timeout;

   assign state   = state_q;
   assign in_flow = (state_q == HUNT) || (state_q == ACTIVE);
   assign pop     = (state_q == ACTIVE) && hs_en && (&avail);
   assign flush   = !hs_en || hunt_entry;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [15:0] win;
      logic [2:0]  k_sel;
      logic        found;

      assign win = {rx_data[8*i +: 8], prev_q[8*i +: 8]};

      // Descending scan so the lowest matching offset is the one kept.
      always_comb begin
         found = 1'b0;
         k_sel = '0;
         for (int k = 7; k >= 0; k--) begin
            if (win[k +: 8] == SYNC_BYTE) begin
               found = 1'b1;
               k_sel = 3'(k);
            end
         end
      end

      assign hit_k[3*i +: 3]    = k_sel;
      assign fifo_din[8*i +: 8] = win[offs_q[3*i +: 3] +: 8];
      assign lock_new[i] = (state_q == HUNT) && rx_valid && !lane_sync[i] && found;
      assign push[i]     = in_flow && rx_valid && lane_sync[i];
      assign avail[i]    = !fifo_empty[i] || push[i];
      assign overflow[i] = push[i] && fifo_full[i] && !pop;

      mipi_rx_fifo #(
         .DEPTH (DESKEW_DEPTH),
         .WIDTH (8)
      ) u_fifo (
         .clk   (clk_in),
         .rst   (rst),
         .flush (flush),
         .push  (push[i]),
         .pop   (pop),
         .din   (fifo_din[8*i +: 8]),
         .dout  (fifo_dout[8*i +: 8]),
         .full  (fifo_full[i]),
         .empty (fifo_empty[i])
      );
   end

   always_comb begin
      state_d    = state_q;
      hunt_entry = 1'b0;
      cnt_inc    = {1'b0, cnt_q} + 9'd1;
      timeout    = (|lane_sync) && rx_valid && (cnt_inc >= 9'(SYNC_TIMEOUT));
      case (state_q)
         IDLE: begin
            if (hs_en && !hs_en_q) begin
               state_d    = HUNT;
               hunt_entry = 1'b1;
            end
         end
         HUNT: begin
            // Overflow beats completion; a final lock beats the timeout.
            if (|overflow)                  state_d = ERROR;
            else if (&(lane_sync | lock_new)) state_d = ACTIVE;
            else if (timeout)               state_d = ERROR;
         end
         ACTIVE: begin
            if (|overflow) state_d = ERROR;
         end
         default: state_d = ERROR;
      endcase
      if (!hs_en) state_d = IDLE;
      err_set = (state_d == ERROR) && (state_q != ERROR);
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         hs_en_q    <= 1'b1;
         cnt_q      <= '0;
         prev_q     <= '0;
         offs_q     <= '0;
         lane_sync  <= '0;
         sync_err   <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
      end else begin
         state_q    <= state_d;
         hs_en_q    <= hs_en;
         byte_valid <= pop;
         if (pop)      byte_data <= fifo_dout;
         if (rx_valid) prev_q    <= rx_data;
         if (flush) begin
            cnt_q     <= '0;
            offs_q    <= '0;
            lane_sync <= '0;
         end else begin
            if ((state_q == HUNT) && (|lane_sync) && rx_valid) cnt_q <= cnt_inc[7:0];
            lane_sync <= lane_sync | lock_new;
            for (int i = 0; i < LANES; i++) begin
               if (lock_new[i]) offs_q[3*i +: 3] <= hit_k[3*i +: 3];
            end
         end
         if (hunt_entry)   sync_err <= 1'b0;
         else if (err_set) sync_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mipi_rx_aligner.sv
// Directed bench for mipi_rx_aligner: two 2-lane instances (timeout 4 and timeout 8) share one stimulus.
// Lane byte streams are built per scenario; expected values are hand-derived constants.

module tb_mipi_rx_aligner;
   logic        clk = 1'b0;
   logic        rst;
   logic        hs_en;
   logic        rx_valid;
   logic [15:0] rx_data;

   logic [15:0] byte_data_a, byte_data_b;
   logic        byte_valid_a, byte_valid_b;
   logic [1:0]  lane_sync_a, lane_sync_b;
   logic        sync_err_a, sync_err_b;
   logic [1:0]  state_a, state_b;

   always #5 clk = ~clk;

   mipi_rx_aligner #(.LANES(2), .DESKEW_DEPTH(4), .SYNC_BYTE(8'hB8), .SYNC_TIMEOUT(4)) dut_a (
      .clk_in(clk), .rst(rst), .hs_en(hs_en), .rx_data(rx_data), .rx_valid(rx_valid),
      .byte_data(byte_data_a), .byte_valid(byte_valid_a), .lane_sync(lane_sync_a),
      .sync_err(sync_err_a), .state(state_a)
   );

   mipi_rx_aligner #(.LANES(2), .DESKEW_DEPTH(4), .SYNC_BYTE(8'hB8), .SYNC_TIMEOUT(8)) dut_b (
      .clk_in(clk), .rst(rst), .hs_en(hs_en), .rx_data(rx_data), .rx_valid(rx_valid),
      .byte_data(byte_data_b), .byte_valid(byte_valid_b), .lane_sync(lane_sync_b),
      .sync_err(sync_err_b), .state(state_b)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [7:0]  l0 [32];
   logic [7:0]  l1 [32];
   int          st_a [32];
   int          st_b [32];
   logic [15:0] o_d [2];
   int          o_i [2];
   int          n_out_a;
   int          n_out_b;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   // lane0: 00 B8 11 22 33 ...; lane1: skew zeros, 00 B8 A1 A2 ..., optionally delayed by shift bits.
   task automatic build(input int skew, input int shift, input bit sync1);
      logic [7:0]  raw [32];
      logic [15:0] t;
      for (int j = 0; j < 32; j++) begin
         l0[j] = (j == 0) ? 8'h00 : (j == 1) ? 8'hB8 : 8'((j - 1) * 17);
         if (!sync1 || j <= skew) raw[j] = 8'h00;
         else if (j == skew + 1)  raw[j] = 8'hB8;
         else                     raw[j] = 8'(32'hA0 + j - skew - 1);
      end
      for (int j = 0; j < 32; j++) begin
         t = {raw[j], (j > 0) ? raw[j-1] : 8'h00};
         l1[j] = t[15 - shift -: 8];
      end
   endtask

   task automatic run(input int n);
      hs_en = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_out_a = 0; n_out_b = 0;
      o_d[0] = 'x; o_d[1] = 'x; o_i[0] = -1; o_i[1] = -1;
      hs_en = 1'b1;
      for (int c = 0; c < n; c++) begin
         rx_valid = 1'b1;
         rx_data  = {l1[c], l0[c]};
         @(posedge clk);
         #1;
         st_a[c] = int'(state_a);
         st_b[c] = int'(state_b);
         if (byte_valid_a) begin
            if (n_out_a < 2) begin
               o_d[n_out_a] = byte_data_a;
               o_i[n_out_a] = c;
            end
            n_out_a++;
         end
         if (byte_valid_b) n_out_b++;
      end
      rx_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; hs_en = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_state",      state_a,      2'd0);
      chk_eq("rst_byte_valid", byte_valid_a, 1'b0);
      chk_eq("rst_byte_data",  byte_data_a,  16'h0000);
      chk_eq("rst_lane_sync",  lane_sync_a,  2'b00);
      chk_eq("rst_sync_err",   sync_err_a,   1'b0);

      // hs_en already high when reset releases must not start a hunt
      hs_en = 1'b1;
      #1 rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         rx_valid = 1'b1;
         rx_data  = (c == 1) ? 16'hB8B8 : 16'h1111;
         @(posedge clk);
         #1;
      end
      chk_eq("no_hunt_after_rst", state_a, 2'd0);

      // aligned lanes, offset 0
      build(0, 0, 1'b1);
      run(8);
      chk_eq("al_hunt",      st_a[1],     32'd1);
      chk_eq("al_first_cyc", o_i[0],      32'd3);
      chk_eq("al_byte0",     o_d[0],      16'hA111);
      chk_eq("al_byte1",     o_d[1],      16'hA222);
      chk_eq("al_second",    o_i[1],      32'd4);
      chk_eq("al_lane_sync", lane_sync_a, 2'b11);
      chk_eq("al_state",     st_a[7],     32'd2);
      chk_eq("al_sync_err",  sync_err_a,  1'b0);

      // hs_en drops while data is still arriving
      rx_valid = 1'b1; rx_data = {l1[8], l0[8]}; hs_en = 1'b0;
      @(posedge clk);
      #1;
      chk_eq("drop_state",      state_a,      2'd0);
      chk_eq("drop_lane_sync",  lane_sync_a,  2'b00);
      chk_eq("drop_byte_valid", byte_valid_a, 1'b0);

      // lane1 delayed by 3 bits
      build(0, 3, 1'b1);
      run(8);
      chk_eq("sh_first_cyc", o_i[0],      32'd3);
      chk_eq("sh_byte0",     o_d[0],      16'hA111);
      chk_eq("sh_byte1",     o_d[1],      16'hA222);
      chk_eq("sh_lane_sync", lane_sync_a, 2'b11);

      // lane1 two bytes late
      build(2, 0, 1'b1);
      run(10);
      chk_eq("sk2_first_cyc", o_i[0],     32'd5);
      chk_eq("sk2_byte0",     o_d[0],     16'hA111);
      chk_eq("sk2_byte1",     o_d[1],     16'hA222);
      chk_eq("sk2_second",    o_i[1],     32'd6);
      chk_eq("sk2_state",     st_a[9],    32'd2);
      chk_eq("sk2_sync_err",  sync_err_a, 1'b0);

      // four bytes late: last lock on the timeout cycle, FIFO exactly full
      build(4, 0, 1'b1);
      run(10);
      chk_eq("sk4_hunt_a",    st_a[5],    32'd1);
      chk_eq("sk4_active_a",  st_a[6],    32'd2);
      chk_eq("sk4_state_b",   st_b[9],    32'd2);
      chk_eq("sk4_err_b",     sync_err_b, 1'b0);
      chk_eq("sk4_first_cyc", o_i[0],     32'd7);
      chk_eq("sk4_byte0",     o_d[0],     16'hA111);

      // five bytes late: overflow in the timeout-8 instance, timeout in the other
      build(5, 0, 1'b1);
      run(10);
      chk_eq("sk5_hunt_b",    st_b[6],    32'd1);
      chk_eq("sk5_ovf_b",     st_b[7],    32'd3);
      chk_eq("sk5_hold_b",    st_b[9],    32'd3);
      chk_eq("sk5_err_b",     sync_err_b, 1'b1);
      chk_eq("sk5_nout_b",    n_out_b,    32'd0);
      chk_eq("sk5_tmo_a",     st_a[6],    32'd3);

      // lane1 never syncs
      build(0, 0, 1'b0);
      run(8);
      chk_eq("tmo_hunt",     st_a[5],    32'd1);
      chk_eq("tmo_error",    st_a[6],    32'd3);
      chk_eq("tmo_sync_err", sync_err_a, 1'b1);
      chk_eq("tmo_nout",     n_out_a,    32'd0);
      hs_en = 1'b0;
      @(posedge clk);
      #1;
      chk_eq("tmo_idle",      state_a,    2'd0);
      chk_eq("tmo_err_kept",  sync_err_a, 1'b1);
      hs_en = 1'b1;
      @(posedge clk);
      #1;
      chk_eq("tmo_rehunt",    state_a,    2'd1);
      chk_eq("tmo_err_clear", sync_err_a, 1'b0);

      // asynchronous reset in the middle of ACTIVE
      build(0, 0, 1'b1);
      run(8);
      chk_eq("pre_rst_valid", byte_valid_a, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk_eq("arst_state",      state_a,      2'd0);
      chk_eq("arst_byte_valid", byte_valid_a, 1'b0);
      chk_eq("arst_byte_data",  byte_data_a,  16'h0000);
      chk_eq("arst_lane_sync",  lane_sync_a,  2'b00);
      rst = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
